// File: rtl/adder_mul_sequencer.sv
// Shift-and-add multiplier controller that drives one shared external WIDTH-bit adder.
// Define ADDER_MUL_SIGNED_EN for two's-complement operands; unsigned-only otherwise.
module adder_mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_op1,
    output logic [WIDTH-1:0]     add_op2,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    count;
    logic             last_step;
    logic             ext;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] q_next;

    assign last_step = (count == LAST);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Sign of the full WIDTH+1 bit sum; the carry alone suffices when unsigned.
`ifdef ADDER_MUL_SIGNED_EN
    assign ext = add_op1[WIDTH-1] ^ add_op2[WIDTH-1] ^ add_cout;
`else
    assign ext = add_cout;
`endif

    assign acc_next = {ext, add_sum[WIDTH-1:1]};
    assign q_next   = {add_sum[0], q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The adder is held at zero outside RUN so its outputs stay deterministic.
    always_comb begin
        next_state = state;
        add_op1    = '0;
        add_op2    = '0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                add_op1 = acc;
                add_op2 = q[0] ? mcand : '0;
`ifdef ADDER_MUL_SIGNED_EN
                // The multiplier sign bit carries negative weight: subtract instead of add.
                if (q[0] && last_step) begin
                    add_op2 = ~mcand;
                    add_cin = 1'b1;
                end
`endif
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            q       <= '0;
            mcand   <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= multiplicand;
                        q     <= multiplier;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    q     <= q_next;
                    count <= count + 1'b1;
                    if (last_step) begin
                        product <= {acc_next, q_next};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
